// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: value-load handshake and multiplexed display bus.
// Ports: load/bin (request), busy/ovf (status), an/hex (display drive).
interface seg7_scan_driver_if #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 14
);
   logic              load;
   logic [WIDTH-1:0]  bin;
   logic              busy;
   logic              ovf;
   logic [DIGITS-1:0] an;
   logic [6:0]        hex;

   modport master (
      output load, bin,
      input  busy, ovf, an, hex
   );

   modport slave (
      input  load, bin,
      output busy, ovf, an, hex
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: binary-to-BCD (shift-add-3) + multiplexed 7-seg scan.
// Ports: clk, rst (sync, active-high), bus (slave: load, bin -> busy, ovf,
// an active-low digit enables, hex active-low segments a..g = bit0..6).
// Option: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_driver #(
   parameter int DIGITS  = 4,
   parameter int WIDTH   = 14,
   parameter int CLK_DIV = 50000
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_driver_if.slave bus
);

   localparam int NB = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [6:0] DASH  = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] p;
      p = 32'd1;
      for (int k = 0; k < n; k++) p = p * 32'd10;
      return p;
   endfunction

   localparam logic [31:0] MAXV = pow10(DIGITS) - 32'd1;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = BLANK;
      endcase
      return g;
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  sr_q, sr_d;
   logic [NB-1:0]     bcd_q, bcd_d;
   logic [NB-1:0]     bcd_adj;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovfp_q, ovfp_d;
   logic              ovf_q, ovf_d;
   logic [NB-1:0]     disp_q, disp_d;

   logic [PW-1:0]     psc_q;
   logic [IW-1:0]     idx_q;
   logic [DIGITS-1:0] an_q, an_d;
   logic [6:0]        hex_q, hex_d;
   logic [3:0]        nib;
   logic              lit;

   // Add-3 correction on every BCD nibble that would reach >=10 after the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ovfp_d  = ovfp_q;
      ovf_d   = ovf_q;
      disp_d  = disp_q;
      unique case (state_q)
         IDLE: begin
            if (bus.load) begin
               sr_d    = bus.bin;
               bcd_d   = '0;
               cnt_d   = '0;
               ovfp_d  = ({{(32-WIDTH){1'b0}}, bus.bin} > MAXV);
               state_d = CONV;
            end
         end
         CONV: begin
            bcd_d  = {bcd_adj[NB-2:0], sr_q[WIDTH-1]};
            sr_d   = sr_q << 1;
            cnt_d  = cnt_q + 1'b1;
            // A carry out of the top digit also means the value cannot fit.
            ovfp_d = ovfp_q | bcd_adj[NB-1];
            if (cnt_q == CW'(WIDTH - 1)) begin
               disp_d  = bcd_d;
               ovf_d   = ovfp_d;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovfp_q  <= 1'b0;
         ovf_q   <= 1'b0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovfp_q  <= ovfp_d;
         ovf_q   <= ovf_d;
         disp_q  <= disp_d;
      end
   end

`ifdef SEG7_LZB_EN
   // keep[i]: some nibble at or above i is non-zero; digit 0 always kept.
   logic [DIGITS-1:0] keep;

   always_comb begin
      logic acc;
      acc  = 1'b0;
      keep = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc     = acc | (disp_q[4*i +: 4] != 4'd0) | (i == 0);
         keep[i] = acc;
      end
   end
`endif

   always_comb begin
      nib  = '0;
      an_d = '1;
      lit  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            nib     = disp_q[4*i +: 4];
            an_d[i] = 1'b0;
`ifdef SEG7_LZB_EN
            lit     = keep[i];
`endif
         end
      end
   end

   always_comb begin
      hex_d = glyph(nib);
      if (ovf_q)
         hex_d = DASH;
      else if (!lit)
         hex_d = BLANK;
   end

   // an/hex are registered together from the same idx, so they switch on one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         psc_q <= '0;
         idx_q <= '0;
         an_q  <= '1;
         hex_q <= BLANK;
      end else begin
         if (psc_q == PW'(CLK_DIV - 1)) begin
            psc_q <= '0;
            if (idx_q == IW'(DIGITS - 1))
               idx_q <= '0;
            else
               idx_q <= idx_q + 1'b1;
         end else begin
            psc_q <= psc_q + 1'b1;
         end
         an_q  <= an_d;
         hex_q <= hex_d;
      end
   end

   assign bus.busy = (state_q == CONV);
   assign bus.ovf  = ovf_q;
   assign bus.an   = an_q;
   assign bus.hex  = hex_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit seven-segment display driver. Accepts an unsigned binary value, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables. It sits between datapath results (adders, counters) and the board's multiplexed display. It replaces per-digit combinational decoders.

## Interface
Parameters:
- DIGITS, 4, number of display digits (1..8)
- WIDTH, 14, binary input width (1..27)
- CLK_DIV, 50000, clock cycles each digit stays enabled (>=2)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- load  input  1  request to convert and display `bin`
- bin  input  WIDTH  unsigned value to display
- busy  output  1  conversion in progress; `load` ignored while high
- ovf  output  1  latched value exceeds 10^DIGITS-1
- an  output  DIGITS  digit enables, active-low, one-hot-low
- hex  output  7  segments, active-low, bit0=a … bit6=g

## Operation
- Glyphs (hex): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- Conversion FSM, states IDLE and CONV:
  - IDLE, load=1: capture bin into the shift register and clear the BCD accumulator (4*DIGITS bits). Evaluate ovf_next = (bin > 10^DIGITS-1). Go to CONV with busy=1 and iteration counter = 0.
  - IDLE, load=0: hold.
  - CONV, each cycle:
    - Add 3 to every BCD nibble that is >=5.
    - Shift the combined {BCD, bin} register left 1 bit.
    - Increment the counter.
  - CONV, on the WIDTH-th iteration: the final BCD value is written into the display register and ovf is updated on the same edge. Return to IDLE with busy=0.
  - CONV, load=1: ignored. There is no queuing.
- Display register holds the last completed result. A display update is atomic, so a partially converted value is never shown.
- Scan:
  - The prescaler counts 0..CLK_DIV-1 and wraps.
  - On a wrap, digit index idx advances 0→1→…→DIGITS-1→0.
- Output registers, updated every cycle from current idx and the display register:
  - an: only bit idx low.
  - hex: the glyph of nibble idx, with two overrides:
    - ovf=1: dash on every digit.
    - Blanking: per Configuration.
- Nibble 0 is the least significant digit and drives an[0].
- Reset mid-conversion: conversion aborts, FSM returns to IDLE, and the display register clears to 0.

## Timing
- Reset values: busy=0, ovf=0, an=all ones, hex=1111111, idx=0, prescaler=0, display register=0.
- First cycle after reset release: an[0]=0, hex=glyph of digit 0.
- load sampled at edge E. busy is high from E through E+WIDTH, i.e. exactly WIDTH cycles. The display register and ovf change at edge E+WIDTH. hex and an reflect the new value at E+WIDTH+1.
- Earliest accepted follow-up load: the cycle busy is low again, i.e. sampled at edge E+WIDTH+1.
- Each digit is enabled for exactly CLK_DIV cycles. One full refresh frame is DIGITS*CLK_DIV cycles.
- an and hex change on the same edge, so there are no ghost cycles with a stale segment pattern.
- A display update between scan wraps takes effect on the current digit the next cycle. The prescaler and idx are never reset by load.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking.
  - Digits above the most significant non-zero nibble show blank.
  - Digit 0 is always shown, so value 0 shows a single "0".
  - ovf dashes take priority over blanking.
- Not defined: every digit shows its glyph, including leading zeros.

## Test plan
Bench parameters: DIGITS=4, WIDTH=14, CLK_DIV=4.
- Reset: hold rst 2 cycles → an=1111, hex=1111111, busy=0, ovf=0. One cycle after release: an=1110, hex=1000000.
- load bin=1234 → busy high exactly 14 cycles. Then, each for 4 cycles:
  - an=1110, hex=0011001
  - an=1101, hex=0110000
  - an=1011, hex=0100100
  - an=0111, hex=1111001
  - The scan then wraps to an=1110.
- load bin=10000 → after conversion ovf=1 and hex=0111111 on all four digits. Then load bin=9999 → ovf=0, and hex=0010000 on all digits.
- load bin=7:
  - With SEG7_LZB_EN: digit0 hex=1111000, digits 1–3 hex=1111111.
  - Without SEG7_LZB_EN: digits 1–3 hex=1000000.
- load bin=42, then pulse load bin=99 while busy → display shows 42; the second request is dropped.
- Assert rst on cycle 5 of a conversion → busy=0 and display shows 0. A subsequent load bin=5 completes normally.
